weight_loader: RTL and testbench

- Loads the classifier parameter memories (W1, B1, W2, B2) from an external 8-bit byte stream.
- Acts as the write side of the weight/bias storage. It issues one registered BRAM write per accepted byte.
- Memories are written in a fixed order: W1, B1, W2, B2.
- The inference controller waits on `loaded` before it starts reading.

---
 rtl/weight_loader.sv | 191 +++++++++++++++++++
 tb/tb_weight_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// Purpose: write side of the classifier parameter memories; loads W1, B1, W2, B2 in order from a byte stream.
// Latency: one cycle from byte acceptance to the registered memory write (wr_en), no bubble between regions.
// Backpressure: s_ready decoded from registered state only; s_valid gaps stall the counter with no write.
//
// Ports:
//   clk, rst          single rising-edge clock, asynchronous active-low reset
//   start, abort      one-cycle pulses; abort has priority and only acts while busy
//   s_valid/s_ready/s_data   8-bit input stream handshake
//   wr_en/wr_sel/wr_addr/wr_data   registered memory write port (sel: 0=W1 1=B1 2=W2 3=B2)
//   busy, done, loaded, err        load status (done is a one-cycle pulse, err is sticky)
//
// Optional feature: define WEIGHT_LOADER_CHECKSUM_EN to append a one-byte trailer
// that must make the modulo-256 sum of all payload bytes zero.
module weight_loader #(
    parameter int W1_DEPTH = 25088,
    parameter int B1_DEPTH = 32,
    parameter int W2_DEPTH = 320,
    parameter int B2_DEPTH = 10,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              wr_en,
    output logic [1:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              loaded,
    output logic              err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LD_W1 = 3'd1;
    localparam logic [2:0] ST_LD_B1 = 3'd2;
    localparam logic [2:0] ST_LD_W2 = 3'd3;
    localparam logic [2:0] ST_LD_B2 = 3'd4;
    localparam logic [2:0] ST_CHK   = 3'd5;
    localparam logic [2:0] ST_FIN   = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              loaded_q, loaded_d;
    logic              in_load;
    logic              payload;
    logic [1:0]        region_sel;
    logic [ADDR_W-1:0] last_addr;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic [7:0] chk_sum;
    logic       err_q, err_d;
    assign chk_sum = sum_q + s_data;
    assign err     = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_load = (state_q == ST_LD_W1) || (state_q == ST_LD_B1) ||
                     (state_q == ST_LD_W2) || (state_q == ST_LD_B2);
    // CHK never becomes the registered state when the checksum is compiled out.
    assign s_ready = in_load || (state_q == ST_CHK);
    assign busy    = s_ready;
    assign done    = (state_q == ST_FIN);
    assign loaded  = loaded_q;
    // Only payload bytes are written; the checksum trailer is consumed silently.
    assign payload = s_valid && in_load;

    always_comb begin
        region_sel = 2'd0;
        last_addr  = ADDR_W'(W1_DEPTH - 1);
        case (state_q)
            ST_LD_B1: begin region_sel = 2'd1; last_addr = ADDR_W'(B1_DEPTH - 1); end
            ST_LD_W2: begin region_sel = 2'd2; last_addr = ADDR_W'(W2_DEPTH - 1); end
            ST_LD_B2: begin region_sel = 2'd3; last_addr = ADDR_W'(B2_DEPTH - 1); end
            default:  begin region_sel = 2'd0; last_addr = ADDR_W'(W1_DEPTH - 1); end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
        err_d    = err_q;
`endif
        if (abort && busy) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            loaded_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // abort in the same cycle as start suppresses the start
                    if (start && !abort) begin
                        state_d  = ST_LD_W1;
                        cnt_d    = '0;
                        loaded_d = 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        sum_d    = 8'd0;
                        err_d    = 1'b0;
`endif
                    end
                end
                ST_LD_W1, ST_LD_B1, ST_LD_W2, ST_LD_B2: begin
                    if (s_valid) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        sum_d = sum_q + s_data;
`endif
                        if (cnt_q == last_addr) begin
                            cnt_d = '0;
                            case (state_q)
                                ST_LD_W1: state_d = ST_LD_B1;
                                ST_LD_B1: state_d = ST_LD_W2;
                                ST_LD_W2: state_d = ST_LD_B2;
                                default: begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                                    state_d = ST_CHK;
`else
                                    state_d  = ST_FIN;
                                    loaded_d = 1'b1;
`endif
                                end
                            endcase
                        end else begin
                            cnt_d = cnt_q + ADDR_W'(1);
                        end
                    end
                end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (s_valid) begin
                        if (chk_sum == 8'd0) begin
                            state_d  = ST_FIN;
                            loaded_d = 1'b1;
                        end else begin
                            state_d  = ST_IDLE;
                            loaded_d = 1'b0;
                            err_d    = 1'b1;
                        end
                    end
                end
`endif
                ST_FIN:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
            wr_en    <= 1'b0;
            wr_sel   <= 2'd0;
            wr_addr  <= '0;
            wr_data  <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
            // A byte accepted on the same edge as abort is still written.
            wr_en    <= payload;
            if (payload) begin
                wr_sel  <= region_sel;
                wr_addr <= cnt_q;
                wr_data <= s_data;
            end
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;

    localparam int W1 = 25088;
    localparam int B1 = 32;
    localparam int W2 = 320;
    localparam int B2 = 10;
    localparam int AW = 15;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          wr_en;
    logic [1:0]    wr_sel;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          done;
    logic          loaded;
    logic          err;

    weight_loader #(
        .W1_DEPTH(W1), .B1_DEPTH(B1), .W2_DEPTH(W2), .B2_DEPTH(B2), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .loaded(loaded), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;

    // expected writes: {sel, addr, data}
    typedef logic [24:0] wr_t;
    wr_t sb[$];

    // loader model
    bit         m_loading = 1'b0;
    int         m_reg     = 0;
    int         m_cnt     = 0;
    logic [7:0] m_sum     = 8'd0;

    logic [7:0] mem_w1 [W1];
    logic [7:0] mem_b1 [B1];
    logic [7:0] mem_w2 [W2];
    logic [7:0] mem_b2 [B2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int depth(input int r);
        case (r)
            0:       return W1;
            1:       return B1;
            2:       return W2;
            default: return B2;
        endcase
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk(tag, {s_ready, wr_en, wr_sel, wr_addr, wr_data, busy, done, loaded, err}, 32'd0);
    endtask

    // One cycle: check handshake status, drive inputs, update model, advance to edge+1.
    task automatic step(input logic v, input logic [7:0] d, input logic st, input logic ab);
        chk("s_ready", s_ready, m_loading);
        chk("busy", busy, m_loading);
        s_valid = v;
        s_data  = d;
        start   = st;
        abort   = ab;
        if (ab) begin
            if (m_loading) begin
                m_loading = 1'b0;
                m_cnt     = 0;
            end
        end else if (m_loading) begin
            if (v) begin
                if (m_reg < 4) begin
                    sb.push_back({2'(m_reg), 15'(m_cnt), d});
                    m_sum = m_sum + d;
                    m_cnt++;
                    if (m_cnt == depth(m_reg)) begin
                        m_cnt = 0;
                        m_reg++;
                        if (m_reg == 4 && !CHK_EN) m_loading = 1'b0;
                    end
                end else begin
                    m_loading = 1'b0;
                end
            end
        end else if (st) begin
            m_loading = 1'b1;
            m_reg     = 0;
            m_cnt     = 0;
            m_sum     = 8'd0;
        end
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every wr_en cycle must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_t exp;
            wr_cnt++;
            chk("write_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk("write", {wr_sel, wr_addr, wr_data}, exp);
            end
            case (wr_sel)
                2'd0:    mem_w1[wr_addr] = wr_data;
                2'd1:    mem_b1[wr_addr] = wr_data;
                2'd2:    mem_w2[wr_addr] = wr_data;
                default: mem_b2[wr_addr] = wr_data;
            endcase
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        logic [7:0] trailer;
        rst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'd0;
        #12;
        chk_outputs_zero("reset_outputs");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // abort together with start in IDLE: nothing starts
        step(1'b0, 8'd0, 1'b1, 1'b1);
        chk("abort_start_idle_busy", busy, 1'b0);

        // Run 1: continuous full load, byte i = i mod 256
        step(1'b0, 8'd0, 1'b1, 1'b0);
        chk("run1_loaded_clear", loaded, 1'b0);
        for (int i = 0; i < 25450; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        trailer = 8'd0 - m_sum;
        step(1'b1, trailer, 1'b0, 1'b0);
        chk("run1_no_write_chk", wr_en, 1'b0);
`else
        chk("run1_final_write", wr_en, 1'b1);
`endif
        chk("run1_done", done, 1'b1);
        chk("run1_loaded", loaded, 1'b1);
        chk("run1_err", err, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        chk("run1_done_pulse", done, 1'b0);
        chk("run1_loaded_hold", loaded, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        chk("run1_writes", wr_cnt, 25450);
        chk("run1_done_count", done_cnt, 1);
        chk("run1_sb_empty", sb.size(), 0);
        chk("w1_last", mem_w1[W1-1], 8'hFF);
        chk("b1_first", mem_b1[0], 8'h00);
        chk("w2_first", mem_w2[0], 8'h20);
        chk("b2_last", mem_b2[B2-1], 8'h69);

        // abort in IDLE has no effect
        step(1'b0, 8'd0, 1'b0, 1'b1);
        chk("idle_abort_loaded", loaded, 1'b1);

        // Run 2: toggled valid with a start pulse mid-W1, then abort 12 bytes into W2
        wr_cnt = 0;
        step(1'b0, 8'd0, 1'b1, 1'b0);
        chk("run2_loaded_clear", loaded, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 8'(i * 3 + 7), (i == 150), 1'b0);
            step(1'b0, 8'hEE, 1'b0, 1'b0);
        end
        chk("run2_toggle_writes", wr_cnt, 300);
        for (int i = 300; i < 25132; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_loaded", loaded, 1'b0);
        chk("abort_s_ready", s_ready, 1'b0);
        chk("abort_wr_en", wr_en, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h55, 1'b0, 1'b0);
        chk("run2_writes", wr_cnt, 25132);
        chk("run2_sb_empty", sb.size(), 0);
        chk("run2_done_count", done_cnt, 1);

        // Run 3: restart begins at W1 address 0
        step(1'b0, 8'd0, 1'b1, 1'b0);
        step(1'b1, 8'hAB, 1'b0, 1'b0);
        chk("restart_wr_en", wr_en, 1'b1);
        chk("restart_sel", wr_sel, 2'd0);
        chk("restart_addr", wr_addr, 15'd0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        for (int i = 1; i < 25450; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        trailer = 8'd1 - m_sum;
        step(1'b1, trailer, 1'b0, 1'b0);
        chk("badchk_err", err, 1'b1);
        chk("badchk_loaded", loaded, 1'b0);
        chk("badchk_done", done, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        chk("badchk_err_sticky", err, 1'b1);
        chk("badchk_done_count", done_cnt, 1);
        chk("badchk_sb_empty", sb.size(), 0);
`else
        for (int i = 1; i < 25220; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("w2_pos_reg", m_reg, 2);
        chk("w2_pos_wr_addr", wr_addr, 15'd99);
        s_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk_outputs_zero("async_reset_outputs");
        sb.delete();
        m_loading = 1'b0;
        m_cnt     = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'h11, 1'b0, 1'b0);
        chk("post_reset_wr_en", wr_en, 1'b0);
        chk("post_reset_loaded", loaded, 1'b0);
        chk("post_reset_done_count", done_cnt, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
